acc_inf_neuron_array: RTL and testbench
=======================================

ACC_INF_NEURON_ARRAY -- requirements
Module: acc_inf_neuron_array

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter N_CH SHALL default to 4 and set the neuron channel count (N_CH >= 2).
REQ-003 Parameter ACC_W SHALL default to 16 and set the signed membrane-voltage width.
REQ-004 Parameter WGT_W SHALL default to 8 and set the signed weight width (WGT_W < ACC_W).
REQ-005 Port clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-006 Port rst SHALL be an input, 1 bit wide: the synchronous active-high reset.
REQ-007 Port load_en SHALL be an input, 1 bit wide: load all accumulators from load_mem_vol.
REQ-008 Port load_mem_vol SHALL be an input, N_CH*ACC_W bits wide: packed initial voltages, channel 0 in the LSBs.
REQ-009 Port input_valid SHALL be an input, 1 bit wide: integrate weight this cycle.
REQ-010 Port weight SHALL be an input, N_CH*WGT_W bits wide: packed signed weights, channel 0 in the LSBs.
REQ-011 Port out_req SHALL be an input, 1 bit wide: start draining all channels.
REQ-012 Port out_valid SHALL be an output, 1 bit wide: out_data/out_ch are valid.
REQ-013 Port out_ready SHALL be an input, 1 bit wide: the consumer accepts the current word.
REQ-014 Port out_data SHALL be an output, ACC_W bits wide: the drained membrane voltage.
REQ-015 Port out_ch SHALL be an output, $clog2(N_CH) bits wide: the index of the drained channel.
REQ-016 Port busy SHALL be an output, 1 bit wide: high while in DRAIN.
REQ-017 Port ovf SHALL be an output, N_CH bits wide: sticky per-channel signed-overflow flags.

Function
REQ-018 The FSM SHALL have two states: ACC (the post-reset state) and DRAIN.
REQ-019 In ACC, priority SHALL be out_req > load_en > input_valid, with one action per cycle.
REQ-020 In ACC, when out_req=1 the FSM SHALL go to DRAIN with out_ch=0 on the next cycle, and load_en/input_valid SHALL be ignored that cycle.
REQ-021 In ACC, when load_en=1 every acc[i] SHALL equal load_mem_vol[i] at the next edge and ovf[i] SHALL clear.
REQ-022 In ACC, when input_valid=1 every acc[i] SHALL equal acc[i] plus sign-extended weight[i] at the next edge (1-cycle latency).
REQ-023 With no action pending, all accumulators SHALL hold their value.
REQ-024 In DRAIN, out_valid SHALL be 1, out_data SHALL equal acc[out_ch], busy SHALL be 1, and load_en/input_valid/out_req SHALL be ignored.
REQ-025 On a handshake (out_valid & out_ready), acc[out_ch] and ovf[out_ch] SHALL clear, and out_ch SHALL increment.
REQ-026 A handshake with out_ch = N_CH-1 SHALL return the FSM to ACC with out_ch=0 and out_valid=0 on the next cycle.
REQ-027 While out_ready=0 in DRAIN, out_data and out_ch SHALL remain stable.
REQ-028 ovf[i] SHALL be set when an integrate's true signed sum falls outside the ACC_W-bit range, and SHALL stay set until channel i is loaded or drained.
REQ-029 The minimum drain time SHALL be N_CH cycles, with out_ready held high.

Reset
REQ-030 While rst=1 at a clock edge, all acc, ovf, out_ch, out_valid and busy SHALL be 0 and the FSM SHALL be in ACC.
REQ-031 Reset mid-DRAIN SHALL abort the drain without a further handshake and SHALL override all other inputs.

Configuration
REQ-032 With macro ACC_INF_SATURATE_EN defined, an overflowing integrate SHALL clamp to the signed maximum 2^(ACC_W-1)-1 or minimum -2^(ACC_W-1).
REQ-033 Without ACC_INF_SATURATE_EN, an overflowing integrate SHALL wrap modulo 2^ACC_W, and ovf SHALL be set identically in both builds.

Verification
REQ-034 Scenario: reset, load {40,30,20,10} (ch3..ch0), then 3 integrates with weight {-1,2,-3,5} -> acc = {37,36,11,25} one cycle after the last integrate.
REQ-035 Scenario: out_req with out_ready=1 -> out_ch 0,1,2,3 on consecutive cycles with out_data 25,11,36,37, then busy=0 and all acc=0.
REQ-036 Scenario: out_ready toggled 1,0,0,1 during the drain -> out_data/out_ch are held during the stalls and each channel is emitted exactly once.
REQ-037 Scenario: ch0 loaded with 32760 then integrated with weight +10 -> ovf[0]=1 and acc[0]=32767 (with SAT) or -32766 (without SAT).
REQ-038 Scenario: out_req, load_en and input_valid asserted in the same cycle -> DRAIN is entered and the accumulators are unchanged.
REQ-039 Scenario: rst=1 asserted while out_ch=2 in DRAIN -> next cycle all outputs are 0 and the FSM is in ACC.

Source files
------------

// File: rtl/acc_inf_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : acc_inf_neuron_array
//  Description : Array of N_CH integrate-and-hold neuron membrane accumulators.
//                Accumulators are loaded in parallel, integrate signed weights,
//                and are drained one channel per handshake over a valid/ready
//                port. Drained channels are cleared. Per-channel sticky
//                signed-overflow flags are kept.
//                Optional macro ACC_INF_SATURATE_EN: overflowing integrates
//                clamp to the signed range instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_inf_neuron_array #(
    parameter int N_CH  = 4,
    parameter int ACC_W = 16,
    parameter int WGT_W = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en,
    input  logic [N_CH*ACC_W-1:0]       load_mem_vol,
    input  logic                        input_valid,
    input  logic [N_CH*WGT_W-1:0]       weight,
    input  logic                        out_req,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_W-1:0]            out_data,
    output logic [$clog2(N_CH)-1:0]     out_ch,
    output logic                        busy,
    output logic [N_CH-1:0]             ovf
);

    localparam int CH_W = $clog2(N_CH);
    localparam logic [CH_W-1:0] C_LAST_CH = CH_W'(N_CH - 1);
`ifdef ACC_INF_SATURATE_EN
    localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [0:0] {
        ST_ACC   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ACC_W-1:0]       r_acc [N_CH];
    logic [N_CH-1:0]        r_ovf;
    logic [CH_W-1:0]        r_ch;
    logic [ACC_W-1:0]       w_int [N_CH];
    logic [N_CH-1:0]        w_add_ovf;
    logic                   w_last;

    assign w_last = (r_ch == C_LAST_CH);

    // Per-channel integrate result: one extra bit catches signed overflow
    // (the top two bits of the widened sum disagree).
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [ACC_W-1:0] w_wext;
        logic [ACC_W:0]   w_sum;

        assign w_wext = {{(ACC_W-WGT_W){weight[g*WGT_W+WGT_W-1]}},
                         weight[g*WGT_W +: WGT_W]};
        assign w_sum  = {r_acc[g][ACC_W-1], r_acc[g]} + {w_wext[ACC_W-1], w_wext};
        assign w_add_ovf[g] = w_sum[ACC_W] ^ w_sum[ACC_W-1];
`ifdef ACC_INF_SATURATE_EN
        // The true sign of the sum lives in the extra MSB.
        assign w_int[g] = w_add_ovf[g] ? (w_sum[ACC_W] ? C_MIN : C_MAX)
                                       : w_sum[ACC_W-1:0];
`else
        assign w_int[g] = w_sum[ACC_W-1:0];
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: drain on request, return after the last channel is accepted
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:   if (out_req) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (out_ready && w_last) w_state_nxt = ST_ACC;
            default:  w_state_nxt = ST_ACC;
        endcase
    end

    // Accumulator datapath: one action per cycle, drain handshakes clear channels
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf <= '0;
            r_ch  <= '0;
        end else if (r_state == ST_DRAIN) begin
            if (out_ready) begin
                r_acc[r_ch] <= '0;
                r_ovf[r_ch] <= 1'b0;
                r_ch        <= w_last ? '0 : r_ch + CH_W'(1);
            end
        end else if (out_req) begin
            r_ch <= '0;
        end else if (load_en) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= load_mem_vol[i*ACC_W +: ACC_W];
            end
            r_ovf <= '0;
        end else if (input_valid) begin
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= w_int[i];
            end
            r_ovf <= r_ovf | w_add_ovf;
        end
    end

    assign out_valid = (r_state == ST_DRAIN);
    assign busy      = (r_state == ST_DRAIN);
    assign out_data  = r_acc[r_ch];
    assign out_ch    = r_ch;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_acc_inf_neuron_array.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_inf_neuron_array
//  Description : Self-checking bench for acc_inf_neuron_array: a directed
//                cycle table followed by randomized traffic compared against
//                an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_inf_neuron_array;

    localparam int N_CH  = 4;
    localparam int ACC_W = 16;
    localparam int WGT_W = 8;
    localparam int AMAX  = 32767;
    localparam int AMIN  = -32768;
`ifdef ACC_INF_SATURATE_EN
    localparam bit SAT  = 1'b1;
    localparam int OV0  = 32767;
    localparam int OV1  = -32768;
`else
    localparam bit SAT  = 1'b0;
    localparam int OV0  = -32766;
    localparam int OV1  = 32767;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    load_en;
    logic [N_CH*ACC_W-1:0]   load_mem_vol;
    logic                    input_valid;
    logic [N_CH*WGT_W-1:0]   weight;
    logic                    out_req;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_data;
    logic [1:0]              out_ch;
    logic                    busy;
    logic [N_CH-1:0]         ovf;

    acc_inf_neuron_array #(.N_CH(N_CH), .ACC_W(ACC_W), .WGT_W(WGT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_mem_vol (load_mem_vol),
        .input_valid  (input_valid),
        .weight       (weight),
        .out_req      (out_req),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .busy         (busy),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [63:0] pk16(input int a3, input int a2, input int a1, input int a0);
        return {a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    endfunction

    function automatic logic [31:0] pk8(input int a3, input int a2, input int a1, input int a0);
        return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
    endfunction

    typedef struct {
        bit          rst;
        bit          ld;
        logic [63:0] ldv;
        bit          iv;
        logic [31:0] wgt;
        bit          req;
        bit          rdy;
        bit          ev;
        int          ech;
        int          edata;
        bit          cd;
        int          eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit ld, input logic [63:0] ldv,
                                input bit iv, input logic [31:0] w, input bit rq,
                                input bit rd, input bit ev, input int ech,
                                input int ed, input bit cd, input int eo);
        vec_t v;
        v.rst = r; v.ld = ld; v.ldv = ldv; v.iv = iv; v.wgt = w; v.req = rq;
        v.rdy = rd; v.ev = ev; v.ech = ech; v.edata = ed; v.cd = cd; v.eovf = eo;
        tbl.push_back(v);
    endfunction

    // Reference model state
    int m_acc [N_CH];
    bit m_ovf [N_CH];
    bit m_drain;
    int m_idx;

    function automatic int model_ovf();
        int r = 0;
        for (int i = 0; i < N_CH; i++) if (m_ovf[i]) r += (1 << i);
        return r;
    endfunction

    function automatic void model_step(input bit r, input bit ld, input logic [63:0] ldv,
                                       input bit iv, input logic [31:0] w,
                                       input bit rq, input bit rd);
        if (r) begin
            for (int i = 0; i < N_CH; i++) begin m_acc[i] = 0; m_ovf[i] = 0; end
            m_drain = 0; m_idx = 0;
        end else if (m_drain) begin
            if (rd) begin
                m_acc[m_idx] = 0; m_ovf[m_idx] = 0;
                if (m_idx == N_CH-1) begin m_drain = 0; m_idx = 0; end
                else m_idx++;
            end
        end else if (rq) begin
            m_drain = 1; m_idx = 0;
        end else if (ld) begin
            for (int i = 0; i < N_CH; i++) begin
                m_acc[i] = int'($signed(ldv[i*16 +: 16]));
                m_ovf[i] = 0;
            end
        end else if (iv) begin
            for (int i = 0; i < N_CH; i++) begin
                int s;
                s = m_acc[i] + int'($signed(w[i*8 +: 8]));
                if (s > AMAX || s < AMIN) begin
                    m_ovf[i] = 1;
                    if (SAT) s = (s > AMAX) ? AMAX : AMIN;
                    else     s = ((s + 32768) & 65535) - 32768;
                end
                m_acc[i] = s;
            end
        end
    endfunction

    initial begin
        rst = 1'b1; load_en = 1'b0; load_mem_vol = '0; input_valid = 1'b0;
        weight = '0; out_req = 1'b0; out_ready = 1'b0;

        //   rst ld ldv                      iv wgt                 req rdy | ev ch data cd ovf
        add(1, 0, 64'd0,                     0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 1, pk16(40,30,20,10),         0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     1, pk8(-1,2,-3,5),     0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     1, pk8(-1,2,-3,5),     0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     1, pk8(-1,2,-3,5),     0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              1, 1,   1, 0, 25, 1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 1, 11, 1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 2, 36, 1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 3, 37, 1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   0, 0, 0,  0, 0);
        // stalled drain
        add(0, 1, pk16(4,3,2,1),             0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              1, 0,   1, 0, 1,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 1, 2,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 0,   1, 1, 2,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 0,   1, 1, 2,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 2, 3,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 3, 4,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   0, 0, 0,  0, 0);
        // drained channels read back as zero
        add(0, 0, 64'd0,                     0, 32'd0,              1, 0,   1, 0, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 1, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 2, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 3, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   0, 0, 0,  0, 0);
        // out_req wins over load/integrate; inputs ignored during drain
        add(0, 1, pk16(8,7,6,5),             0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 1, pk16(99,99,99,99),         1, pk8(1,1,1,1),       1, 0,   1, 0, 5,  1, 0);
        add(0, 1, pk16(99,99,99,99),         1, pk8(1,1,1,1),       1, 1,   1, 1, 6,  1, 0);
        add(0, 1, pk16(99,99,99,99),         1, pk8(1,1,1,1),       1, 1,   1, 2, 7,  1, 0);
        add(0, 1, pk16(99,99,99,99),         1, pk8(1,1,1,1),       1, 1,   1, 3, 8,  1, 0);
        add(0, 1, pk16(99,99,99,99),         1, pk8(1,1,1,1),       1, 1,   0, 0, 0,  0, 0);
        // positive and negative overflow, sticky flags, cleared by drain
        add(0, 1, pk16(0,0,-32768,32760),    0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     1, pk8(0,0,-1,10),     0, 0,   0, 0, 0,  0, 3);
        add(0, 0, 64'd0,                     1, pk8(0,0,0,0),       0, 0,   0, 0, 0,  0, 3);
        add(0, 0, 64'd0,                     0, 32'd0,              1, 0,   1, 0, OV0, 1, 3);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 1, OV1, 1, 2);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 2, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 0,   1, 2, 0,  1, 0);
        // reset mid-drain at out_ch=2 overrides everything
        add(1, 1, pk16(5,5,5,5),             1, pk8(1,1,1,1),       1, 1,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              1, 0,   1, 0, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 1, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 2, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   1, 3, 0,  1, 0);
        add(0, 0, 64'd0,                     0, 32'd0,              0, 1,   0, 0, 0,  0, 0);
        // load clears a sticky flag
        add(0, 1, pk16(0,0,0,32767),         0, 32'd0,              0, 0,   0, 0, 0,  0, 0);
        add(0, 0, 64'd0,                     1, pk8(0,0,0,1),       0, 0,   0, 0, 0,  0, 1);
        add(0, 1, pk16(0,0,0,0),             0, 32'd0,              0, 0,   0, 0, 0,  0, 0);

        foreach (tbl[k]) begin
            rst = tbl[k].rst; load_en = tbl[k].ld; load_mem_vol = tbl[k].ldv;
            input_valid = tbl[k].iv; weight = tbl[k].wgt; out_req = tbl[k].req;
            out_ready = tbl[k].rdy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", k), int'(out_valid), int'(tbl[k].ev));
            chk($sformatf("vec%0d_busy", k),  int'(busy),      int'(tbl[k].ev));
            chk($sformatf("vec%0d_ch", k),    int'(out_ch),    tbl[k].ech);
            chk($sformatf("vec%0d_ovf", k),   int'(ovf),       tbl[k].eovf);
            if (tbl[k].cd)
                chk($sformatf("vec%0d_data", k), int'($signed(out_data)), tbl[k].edata);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            int sel;
            rst         = (n == 0) || ($urandom_range(0, 59) == 0);
            load_en     = ($urandom_range(0, 5) == 0);
            input_valid = ($urandom_range(0, 1) == 0);
            out_req     = ($urandom_range(0, 11) == 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < N_CH; i++) begin
                int v;
                sel = $urandom_range(0, 3);
                if (sel == 0)      v = AMAX - $urandom_range(0, 100);
                else if (sel == 1) v = AMIN + $urandom_range(0, 100);
                else               v = $urandom_range(0, 65535) - 32768;
                load_mem_vol[i*16 +: 16] = v[15:0];
                weight[i*8 +: 8]         = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            model_step(rst, load_en, load_mem_vol, input_valid, weight, out_req, out_ready);
            chk("rnd_valid", int'(out_valid), int'(m_drain));
            chk("rnd_busy",  int'(busy),      int'(m_drain));
            chk("rnd_ch",    int'(out_ch),    m_idx);
            chk("rnd_ovf",   int'(ovf),       model_ovf());
            if (m_drain)
                chk("rnd_data", int'($signed(out_data)), m_acc[m_idx]);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
